core_inst_seq: RTL and testbench
================================

CORE_INST_SEQ -- requirements
Module: core_inst_seq

Interface
REQ-001 Parameters SHALL be: row = 8, PE rows; col = 8, PE columns; len_nij = 36, input pixels (6x6); len_kij = 9, kernel taps (3x3); len_onij = 16, output pixels (4x4).
REQ-002 clk  input  1  single clock; every output changes only on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that begins a full conv run; ignored unless in IDLE.
REQ-005 ofifo_valid  input  1  core OFIFO holds a complete psum row.
REQ-006 inst  output  35  core instruction word: [34] relu, [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 out_valid  output  1  one-cycle pulse when one output pixel has finished accumulating in the SFP.
REQ-009 done  output  1  one-cycle pulse when the run completes.

Function
REQ-010 The FSM SHALL have the states IDLE, W_L0, K_LOAD, GAP, A_L0, EXEC, DRAIN, O_RD, ACC, ACC_GAP and FIN; a kij counter (0..8) and an onij counter (0..15) SHALL select the current tap and output pixel.
REQ-011 Idle instruction word: CEN/WEN of both memories = 1; every other bit = 0; addresses = 0.
REQ-012 In IDLE, start SHALL clear both counters and move the FSM to W_L0.
REQ-013 W_L0 SHALL last col cycles (t = 0..7) and drive CEN_xmem=0, WEN_xmem=1, A_xmem=1024+kij*col+t, l0_wr=1.
REQ-014 K_LOAD SHALL last col cycles and drive l0_rd=1 and load=1.
REQ-015 GAP SHALL last 10 cycles with the idle instruction word.
REQ-016 A_L0 SHALL last len_nij cycles and drive CEN_xmem=0, WEN_xmem=1, A_xmem=t (t = 0..35), l0_wr=1.
REQ-017 EXEC SHALL last len_nij cycles and drive l0_rd=1 and execute=1.
REQ-018 DRAIN SHALL hold the idle word until ofifo_valid=1, then move to O_RD.
REQ-019 In O_RD, each cycle with ofifo_valid=1 SHALL drive ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=kij*36+r and then increment r.
REQ-020 In O_RD, a cycle with ofifo_valid=0 SHALL drive the idle word and SHALL NOT advance r (stall, no lost or duplicated row).
REQ-021 After r reaches 36: if kij<8, kij SHALL increment and the FSM SHALL return to W_L0; otherwise the FSM SHALL enter ACC with onij=0.
REQ-022 ACC SHALL last len_kij+1 cycles (j = 0..9).
  - For j<9: CEN_pmem=0, WEN_pmem=1, A_pmem=j*36 + (onij/4 + j/3)*6 + onij%4 + j%3.
  - For j=9: CEN_pmem=1.
  - acc=1 for j>=1 (one cycle behind the read, matching 1-cycle pmem latency).
REQ-023 ACC_GAP SHALL last 1 cycle with acc=0 and out_valid=1; then, if onij<15, onij SHALL increment and the FSM SHALL re-enter ACC, otherwise it SHALL go to FIN.
REQ-024 FIN SHALL pulse done for 1 cycle and return to IDLE.
REQ-025 All address arithmetic SHALL be unsigned 11-bit; maximum pmem address = 8*36+35 = 323, with no wrap.
REQ-026 A start pulse while busy=1 SHALL be ignored.

Reset
REQ-027 With reset=0 at a rising edge, the block SHALL return to IDLE with the idle instruction word, clear both counters and hold busy=0, out_valid=0, done=0; this applies from any state, mid-run included.
REQ-028 After reset is released, no instruction other than the idle word SHALL be issued until the next start.

Configuration
REQ-029 With macro CORE_INST_SEQ_RELU_EN defined, inst[34] SHALL be 1 in ACC cycle j=9 and in ACC_GAP; without it, inst[34] SHALL be tied to 0.

Verification
REQ-030 reset low 3 cycles, mid-EXEC of kij=4 -> next cycle is the idle word; busy=0; a subsequent start restarts from kij=0.
REQ-031 start with ofifo_valid tied 1 -> A_xmem sequence 1024..1031, then 0..35; 36 pmem writes per kij at 0..35, 36..71, ... 288..323; done after 16 out_valid pulses.
REQ-032 During O_RD, ofifo_valid toggles 1,0,0,1 -> exactly 2 writes, to consecutive addresses with no gap.
REQ-033 Accumulation for onij=5 -> A_pmem reads 7, 44, 81, 121, 158, 195, 235, 272, 309; acc high on the 9 cycles following the first read.
REQ-034 start pulsed again during W_L0 -> counters and state are unaffected.
REQ-035 Build with CORE_INST_SEQ_RELU_EN -> relu=1 exactly on ACC j=9 and on ACC_GAP; build without it -> relu=0 throughout.

Source files
------------

// File: rtl/core_inst_seq_if.sv
// ---------------------------------------------------------------------------
// core_inst_seq_if
// Handshake and instruction bus between the convolution sequencer and the
// core it drives.
//   start       : host -> sequencer, one-cycle pulse that begins a conv run
//   ofifo_valid : core -> sequencer, OFIFO holds a complete psum row
//   inst[34:0]  : sequencer -> core, instruction word
//   busy        : sequencer -> host, high whenever the sequencer is not idle
//   out_valid   : sequencer -> host, one output pixel finished accumulating
//   done        : sequencer -> host, run complete
// modport master : the sequencer (drives the instruction word)
// modport slave  : the core/host side
// ---------------------------------------------------------------------------
interface core_inst_seq_if;
    logic        start;
    logic        ofifo_valid;
    logic [34:0] inst;
    logic        busy;
    logic        out_valid;
    logic        done;

    modport master (
        input  start,
        input  ofifo_valid,
        output inst,
        output busy,
        output out_valid,
        output done
    );

    modport slave (
        output start,
        output ofifo_valid,
        input  inst,
        input  busy,
        input  out_valid,
        input  done
    );
endinterface

// File: rtl/core_inst_seq.sv
// ---------------------------------------------------------------------------
// core_inst_seq
// Instruction sequencer for one full 3x3 convolution over a 6x6 input on an
// 8x8 PE core: for every kernel tap it loads weights and activations into L0,
// executes, and drains the OFIFO psum rows into pmem; it then walks pmem to
// accumulate the 9 taps of each of the 16 output pixels through the SFP.
// Ports:
//   clk   : single clock, all outputs registered on its rising edge
//   reset : synchronous, active-low
//   bus   : core_inst_seq_if.master (start, ofifo_valid, inst, busy,
//           out_valid, done)
// Optional feature: define CORE_INST_SEQ_RELU_EN to assert the relu bit on
// the last accumulate cycle and on the gap cycle; otherwise relu is tied 0.
// ---------------------------------------------------------------------------
module core_inst_seq #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int len_nij  = 36,
    parameter int len_kij  = 9,
    parameter int len_onij = 16
) (
    input  logic           clk,
    input  logic           reset,
    core_inst_seq_if.master bus
);

    // Instruction word bit positions
    localparam int B_RELU     = 34;
    localparam int B_ACC      = 33;
    localparam int B_CEN_PMEM = 32;
    localparam int B_WEN_PMEM = 31;
    localparam int B_CEN_XMEM = 19;
    localparam int B_WEN_XMEM = 18;
    localparam int B_OFIFO_RD = 6;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXECUTE  = 1;
    localparam int B_LOAD     = 0;

    // Both memories disabled (CEN/WEN high), everything else low
    localparam logic [34:0] IDLE_WORD = 35'h1_800C_0000;

    // Geometry of the 6x6 input, 4x4 output, 3x3 kernel
    localparam int IN_W  = 6;
    localparam int OUT_W = 4;
    localparam int K_W   = 3;

    // Weights live above the activations in xmem
    localparam int W_BASE = 1024;

    localparam logic [5:0] COL_LAST  = 6'(col - 1);
    localparam logic [5:0] NIJ_LAST  = 6'(len_nij - 1);
    localparam logic [5:0] NIJ_CNT   = 6'(len_nij);
    localparam logic [5:0] GAP_LAST  = 6'd9;
    localparam logic [5:0] ACC_LAST  = 6'(len_kij);
    localparam logic [3:0] KIJ_LAST  = 4'(len_kij - 1);
    localparam logic [3:0] ONIJ_LAST = 4'(len_onij - 1);

    typedef enum logic [3:0] {
        IDLE, W_L0, K_LOAD, GAP, A_L0, EXEC, DRAIN, O_RD, ACC, ACC_GAP, FIN
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  t_q, t_d;        // cycle index within the state (r in O_RD, j in ACC)
    logic [3:0]  kij_q, kij_d;
    logic [3:0]  onij_q, onij_d;
    logic        wr_q, wr_d;      // O_RD cycle carries a pmem write
    logic [5:0]  r_next;
    logic [34:0] inst_q;
    logic        busy_q, out_valid_q, done_q;

    // pmem read address for tap j of output pixel onij
    function automatic logic [10:0] acc_addr(input logic [5:0] j, input logic [3:0] onij);
        int ji;
        int oi;
        ji = int'(j);
        oi = int'(onij);
        return 11'(ji * len_nij + (oi / OUT_W + ji / K_W) * IN_W + oi % OUT_W + ji % K_W);
    endfunction

    // Instruction word issued during a cycle of the given state
    function automatic logic [34:0] decode(input state_t s, input logic [5:0] t,
                                           input logic [3:0] kij, input logic [3:0] onij,
                                           input logic wr);
        logic [34:0] w;
        w = IDLE_WORD;
        case (s)
            W_L0: begin
                w[B_CEN_XMEM] = 1'b0;
                w[17:7]       = 11'(W_BASE + int'(kij) * col + int'(t));
                w[B_L0_WR]    = 1'b1;
            end
            K_LOAD: begin
                w[B_L0_RD] = 1'b1;
                w[B_LOAD]  = 1'b1;
            end
            A_L0: begin
                w[B_CEN_XMEM] = 1'b0;
                w[17:7]       = 11'(t);
                w[B_L0_WR]    = 1'b1;
            end
            EXEC: begin
                w[B_L0_RD]   = 1'b1;
                w[B_EXECUTE] = 1'b1;
            end
            O_RD: begin
                if (wr) begin
                    w[B_OFIFO_RD] = 1'b1;
                    w[B_CEN_PMEM] = 1'b0;
                    w[B_WEN_PMEM] = 1'b0;
                    w[30:20]      = 11'(int'(kij) * len_nij + int'(t));
                end
            end
            ACC: begin
                if (t != ACC_LAST) begin
                    w[B_CEN_PMEM] = 1'b0;
                    w[30:20]      = acc_addr(t, onij);
                end
                // pmem data arrives one cycle after the address
                w[B_ACC] = (t != 6'd0);
`ifdef CORE_INST_SEQ_RELU_EN
                w[B_RELU] = (t == ACC_LAST);
`endif
            end
            ACC_GAP: begin
`ifdef CORE_INST_SEQ_RELU_EN
                w[B_RELU] = 1'b1;
`endif
            end
            default: ;
        endcase
        return w;
    endfunction

    // Rows written so far in O_RD, including this cycle's write
    assign r_next = t_q + 6'(wr_q);

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        kij_d   = kij_q;
        onij_d  = onij_q;
        wr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = W_L0;
                    t_d     = '0;
                    kij_d   = '0;
                    onij_d  = '0;
                end
            end
            W_L0: begin
                if (t_q == COL_LAST) begin
                    state_d = K_LOAD;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 6'd1;
                end
            end
            K_LOAD: begin
                if (t_q == COL_LAST) begin
                    state_d = GAP;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 6'd1;
                end
            end
            GAP: begin
                if (t_q == GAP_LAST) begin
                    state_d = A_L0;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 6'd1;
                end
            end
            A_L0: begin
                if (t_q == NIJ_LAST) begin
                    state_d = EXEC;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 6'd1;
                end
            end
            EXEC: begin
                if (t_q == NIJ_LAST) begin
                    state_d = DRAIN;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 6'd1;
                end
            end
            DRAIN: begin
                if (bus.ofifo_valid) begin
                    state_d = O_RD;
                    t_d     = '0;
                    wr_d    = 1'b1;
                end
            end
            O_RD: begin
                // A valid row seen at this edge becomes the next cycle's write,
                // so r only moves on cycles that actually wrote.
                if (r_next == NIJ_CNT) begin
                    t_d = '0;
                    if (kij_q == KIJ_LAST) begin
                        state_d = ACC;
                        onij_d  = '0;
                    end else begin
                        state_d = W_L0;
                        kij_d   = kij_q + 4'd1;
                    end
                end else begin
                    t_d  = r_next;
                    wr_d = bus.ofifo_valid;
                end
            end
            ACC: begin
                if (t_q == ACC_LAST) begin
                    state_d = ACC_GAP;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 6'd1;
                end
            end
            ACC_GAP: begin
                t_d = '0;
                if (onij_q == ONIJ_LAST) begin
                    state_d = FIN;
                end else begin
                    state_d = ACC;
                    onij_d  = onij_q + 4'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state
    // they belong to while still coming straight out of flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            t_q         <= '0;
            kij_q       <= '0;
            onij_q      <= '0;
            wr_q        <= 1'b0;
            inst_q      <= IDLE_WORD;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            kij_q       <= kij_d;
            onij_q      <= onij_d;
            wr_q        <= wr_d;
            inst_q      <= decode(state_d, t_d, kij_d, onij_d, wr_d);
            busy_q      <= (state_d != IDLE);
            out_valid_q <= (state_d == ACC_GAP);
            done_q      <= (state_d == FIN);
        end
    end

    assign bus.inst      = inst_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_core_inst_seq.sv
module tb_core_inst_seq;

    localparam logic [34:0] IDLE_WORD = 35'h1_800C_0000;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    core_inst_seq_if bus_if ();

    core_inst_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge; inputs are
    // changed at the same point so they are stable at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] a_xmem();
        return bus_if.inst[17:7];
    endfunction

    function automatic logic [10:0] a_pmem();
        return bus_if.inst[30:20];
    endfunction

    function automatic logic is_xrd();
        return !bus_if.inst[19] && bus_if.inst[18];
    endfunction

    function automatic logic is_pwr();
        return !bus_if.inst[32] && !bus_if.inst[31];
    endfunction

    function automatic logic is_prd();
        return !bus_if.inst[32] && bus_if.inst[31];
    endfunction

    task automatic apply_reset(input int n);
        reset = 1'b0;
        bus_if.start = 1'b0;
        repeat (n) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus_if.start = 1'b0;
        bus_if.ofifo_valid = 1'b1;
        repeat (3) tick();
        vectors++;
        if (bus_if.inst !== IDLE_WORD) begin
            miscompares++;
            $display("FAIL reset_inst: got %h expected %h", bus_if.inst, IDLE_WORD);
        end
        vectors++;
        if ({bus_if.busy, bus_if.out_valid, bus_if.done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got busy/ov/done=%b expected 000",
                     {bus_if.busy, bus_if.out_valid, bus_if.done});
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (bus_if.inst !== IDLE_WORD || bus_if.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_idle: cycle %0d inst %h busy %b expected %h busy 0",
                         i, bus_if.inst, bus_if.busy, IDLE_WORD);
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_full_run();
        int   xq[$];
        int   n_x, n_pw, n_pr, n_ov, cyc, on, j, exp_a;
        logic prev_rd, fin, exp_relu;
        int   onij5[9] = '{7, 44, 81, 121, 158, 195, 235, 272, 309};

        for (int k = 0; k < 9; k++) begin
            for (int t = 0; t < 8; t++) xq.push_back(1024 + k * 8 + t);
            for (int t = 0; t < 36; t++) xq.push_back(t);
        end
        n_x = 0; n_pw = 0; n_pr = 0; n_ov = 0;
        prev_rd = 1'b0;
        fin = 1'b0;
        bus_if.ofifo_valid = 1'b1;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (is_xrd()) begin
                exp_a = (n_x < 396) ? xq[n_x] : -1;
                vectors++;
                if (int'(a_xmem()) != exp_a || bus_if.inst[2] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL xmem_addr: read %0d got %0d l0_wr %b expected %0d l0_wr 1",
                             n_x, a_xmem(), bus_if.inst[2], exp_a);
                end
                n_x++;
            end
            if (is_pwr()) begin
                vectors++;
                if (int'(a_pmem()) != n_pw || bus_if.inst[6] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL pmem_write: write %0d got addr %0d ofifo_rd %b expected addr %0d ofifo_rd 1",
                             n_pw, a_pmem(), bus_if.inst[6], n_pw);
                end
                n_pw++;
            end
            if (is_prd()) begin
                on = n_pr / 9;
                j  = n_pr % 9;
                exp_a = j * 36 + (on / 4 + j / 3) * 6 + on % 4 + j % 3;
                vectors++;
                if (int'(a_pmem()) != exp_a) begin
                    miscompares++;
                    $display("FAIL pmem_read: onij %0d j %0d got %0d expected %0d",
                             on, j, a_pmem(), exp_a);
                end
                if (on == 5) begin
                    vectors++;
                    if (int'(a_pmem()) != onij5[j]) begin
                        miscompares++;
                        $display("FAIL onij5_read: j %0d got %0d expected %0d",
                                 j, a_pmem(), onij5[j]);
                    end
                end
                n_pr++;
            end
            vectors++;
            if (bus_if.inst[33] !== prev_rd) begin
                miscompares++;
                $display("FAIL acc_bit: cycle %0d got %b expected %b", cyc, bus_if.inst[33], prev_rd);
            end
`ifdef CORE_INST_SEQ_RELU_EN
            exp_relu = bus_if.out_valid || (prev_rd && bus_if.inst[32]);
`else
            exp_relu = 1'b0;
`endif
            vectors++;
            if (bus_if.inst[34] !== exp_relu) begin
                miscompares++;
                $display("FAIL relu_bit: cycle %0d got %b expected %b", cyc, bus_if.inst[34], exp_relu);
            end
            vectors++;
            if (bus_if.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_run: cycle %0d got %b expected 1", cyc, bus_if.busy);
            end
            if (bus_if.out_valid === 1'b1) n_ov++;
            if (bus_if.done === 1'b1) begin
                vectors++;
                if (n_ov != 16) begin
                    miscompares++;
                    $display("FAIL done_after_ov: got %0d out_valid pulses before done expected 16", n_ov);
                end
                fin = 1'b1;
            end
            prev_rd = is_prd();
            if (!fin) tick();
        end
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL run_timeout: done not seen within 3000 cycles expected done");
        end
        vectors++;
        if (n_x != 396 || n_pw != 324 || n_pr != 144 || n_ov != 16) begin
            miscompares++;
            $display("FAIL run_totals: got xrd %0d pwr %0d prd %0d ov %0d expected 396 324 144 16",
                     n_x, n_pw, n_pr, n_ov);
        end
        tick();
        vectors++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.inst !== IDLE_WORD) begin
            miscompares++;
            $display("FAIL after_done: got busy %b done %b inst %h expected 0 0 %h",
                     bus_if.busy, bus_if.done, bus_if.inst, IDLE_WORD);
        end
        $display("test_full_run: %0d xmem reads, %0d pmem writes, %0d pmem reads, %0d pixels",
                 n_x, n_pw, n_pr, n_ov);
    endtask

    task automatic test_back_to_back();
        bus_if.ofifo_valid = 1'b1;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        vectors++;
        if (!is_xrd() || a_xmem() !== 11'd1024 || bus_if.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL back_to_back_start: got xrd %b addr %0d busy %b expected 1 1024 1",
                     is_xrd(), a_xmem(), bus_if.busy);
        end
        apply_reset(2);
        $display("test_back_to_back: done");
    endtask

    task automatic test_start_ignored();
        bus_if.ofifo_valid = 1'b1;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int t = 0; t < 8; t++) begin
            bus_if.start = (t == 2);
            vectors++;
            if (!is_xrd() || int'(a_xmem()) != 1024 + t) begin
                miscompares++;
                $display("FAIL start_busy_wl0: t %0d got xrd %b addr %0d expected 1 %0d",
                         t, is_xrd(), a_xmem(), 1024 + t);
            end
            tick();
        end
        bus_if.start = 1'b0;
        for (int t = 0; t < 8; t++) begin
            vectors++;
            if (bus_if.inst[0] !== 1'b1 || bus_if.inst[3] !== 1'b1) begin
                miscompares++;
                $display("FAIL start_busy_kload: t %0d got load %b l0_rd %b expected 1 1",
                         t, bus_if.inst[0], bus_if.inst[3]);
            end
            tick();
        end
        vectors++;
        if (bus_if.inst !== IDLE_WORD) begin
            miscompares++;
            $display("FAIL start_busy_gap: got %h expected %h", bus_if.inst, IDLE_WORD);
        end
        apply_reset(2);
        $display("test_start_ignored: done");
    endtask

    task automatic test_mid_reset();
        int  k4_seen, ex_cnt, cyc;
        logic hit;
        k4_seen = 0; ex_cnt = 0; hit = 1'b0;
        bus_if.ofifo_valid = 1'b1;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (cyc = 0; cyc < 2000 && !hit; cyc++) begin
            if (is_xrd() && a_xmem() == 11'd1056) k4_seen = 1;
            if (k4_seen != 0 && bus_if.inst[1] === 1'b1) ex_cnt++;
            if (ex_cnt == 10) hit = 1'b1;
            else tick();
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL mid_reset_reach: kij=4 EXEC not reached expected reached");
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus_if.inst !== IDLE_WORD || bus_if.busy !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_reset_idle: cycle %0d got inst %h busy %b expected %h 0",
                         i, bus_if.inst, bus_if.busy, IDLE_WORD);
            end
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (bus_if.inst !== IDLE_WORD || bus_if.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_release: got inst %h busy %b expected %h 0",
                     bus_if.inst, bus_if.busy, IDLE_WORD);
        end
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        vectors++;
        if (!is_xrd() || a_xmem() !== 11'd1024) begin
            miscompares++;
            $display("FAIL mid_reset_restart: got xrd %b addr %0d expected 1 1024", is_xrd(), a_xmem());
        end
        apply_reset(2);
        $display("test_mid_reset: done");
    endtask

    task automatic test_stall();
        int   cyc, n_wr;
        int   wa[$];
        logic seen_ex, in_drain;
        logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        seen_ex = 1'b0; in_drain = 1'b0;
        bus_if.ofifo_valid = 1'b0;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (cyc = 0; cyc < 500 && !in_drain; cyc++) begin
            if (bus_if.inst[1] === 1'b1) seen_ex = 1'b1;
            else if (seen_ex) in_drain = 1'b1;
            if (!in_drain) tick();
        end
        vectors++;
        if (!in_drain) begin
            miscompares++;
            $display("FAIL stall_reach: DRAIN not reached expected reached");
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus_if.inst !== IDLE_WORD || bus_if.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL drain_hold: cycle %0d got inst %h busy %b expected %h 1",
                         i, bus_if.inst, bus_if.busy, IDLE_WORD);
            end
            tick();
        end
        n_wr = 0;
        for (int i = 0; i < 12; i++) begin
            bus_if.ofifo_valid = (i < 4) ? pat[i] : 1'b0;
            tick();
            if (is_pwr()) begin
                n_wr++;
                wa.push_back(int'(a_pmem()));
            end
        end
        vectors++;
        if (n_wr != 2) begin
            miscompares++;
            $display("FAIL stall_count: got %0d writes expected 2", n_wr);
        end else begin
            vectors++;
            if (wa[0] != 0 || wa[1] != 1) begin
                miscompares++;
                $display("FAIL stall_addr: got %0d,%0d expected 0,1", wa[0], wa[1]);
            end
        end
        apply_reset(2);
        $display("test_stall: %0d writes", n_wr);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        bus_if.start = 1'b0;
        bus_if.ofifo_valid = 1'b0;
        test_reset();
        test_full_run();
        test_back_to_back();
        test_start_ignored();
        test_mid_reset();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
